sap1_controller_sequencer: RTL and testbench
============================================

// Module: sap1_controller_sequencer
// PURPOSE
//   Control side of the SAP-1 datapath. It drives the adder-subtracter's SUB and enable lines and every register load/enable strobe.
//   A 6-state ring counter (T1..T6) sequences fetch (T1-T3) and execute (T4-T6). Control outputs decode from ring state and IR opcode.
//   It is the initiator for the adder-subtracter, A/B registers, PC, MAR, RAM, IR and output register.
// PARAMETERS
//   OP_LDA  4'h0  opcode: load A from RAM[addr]
//   OP_ADD  4'h1  opcode: A <= A + RAM[addr]
//   OP_SUB  4'h2  opcode: A <= A - RAM[addr]
//   OP_OUT  4'hE  opcode: output register <= A
//   OP_HLT  4'hF  opcode: stop sequencing
// PORTS
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous, active-high reset
//   opcode  in   4  IR upper nibble; stable from the edge ending T3 onward
//   cp      out  1  PC increment
//   ep      out  1  PC drives bus
//   lm      out  1  MAR load from bus
//   ce      out  1  RAM drives bus
//   li      out  1  IR load from bus
//   ei      out  1  IR address nibble drives bus
//   la      out  1  A register load from bus
//   ea      out  1  A register drives bus
//   su      out  1  adder-subtracter SUB select (1 = subtract)
//   eu      out  1  adder-subtracter drives bus
//   lb      out  1  B register load from bus
//   lo      out  1  output register load from bus
//   tstate  out  6  one-hot ring state; bit0 = T1
//   halted  out  1  1 after HLT executes; cleared only by rst
// BEHAVIOUR
//   - Reset state: tstate = 6'b000001, halted = 0. Control outputs then show T1 decode: ep = lm = 1, all others 0.
//   - Ring: advances one position per clk (T6 wraps to T1) while halted = 0. No skip states; every instruction takes 6 cycles.
//   - All control outputs are combinational from (tstate, opcode, halted), so there is zero-cycle latency from state to strobe.
//     Loads take effect at the rising edge that ends the state.
//   - Fetch, for any opcode: T1 ep,lm | T2 cp | T3 ce,li.
//   - LDA:     T4 ei,lm | T5 ce,la | T6 none.
//   - ADD:     T4 ei,lm | T5 ce,lb | T6 eu,la, su = 0.
//   - SUB:     T4 ei,lm | T5 ce,lb | T6 eu,la,su.
//   - su is asserted only in T6 of SUB. It is 0 in every other cycle.
//   - OUT:     T4 ea,lo | T5 none | T6 none.
//   - HLT:     T4 none. At the edge ending T4, halted <= 1 and tstate holds at T4 (6'b001000).
//   - Undefined opcodes (4'h3..4'hD) are NOPs: no strobes in T4-T6, and the ring keeps running.
//   - While halted = 1: all control outputs are 0 and tstate is frozen. The clock has no effect until rst.
//   - Bus exclusivity invariant: at most one of {ep, ce, ei, ea, eu} is 1 in any cycle.
//   - Reset mid-instruction (any T, halted or not): rst wins. The next edge gives T1 with halted = 0, and partial execute strobes are abandoned.
//   - rst held for several cycles: state stays at T1 and outputs stay at T1 decode.
// TESTING
//   1. Reset: rst = 1 for 2 clk, then 0.
//      -> tstate = 000001, ep = lm = 1, halted = 0; T2 gives cp = 1; T3 gives ce = li = 1.
//   2. LDA (opcode = 0): run 6 clk.
//      -> T4 ei,lm; T5 ce,la; T6 no strobes; the clk after T6 gives tstate = 000001.
//   3. ADD then SUB (opcode 1, then 2):
//      -> ADD T6: eu = la = 1, su = 0. SUB T6: eu = la = su = 1. su = 0 in all other cycles.
//   4. HLT (opcode = F): run 10 clk.
//      -> halted = 1 after the T4 edge; tstate stays 001000; all strobes are 0 for the remaining cycles.
//   5. Reset mid-op: opcode = 2, assert rst during T5.
//      -> next edge gives tstate = 000001, lb not reasserted; reset while halted gives halted = 0 and T1.
//   6. Undefined opcode 4'h7 for 12 clk.
//      -> no strobes in T4-T6, ring wraps normally. Check the bus-exclusivity invariant every cycle in all tests.

Source files
------------

// File: rtl/sap1_controller_sequencer.sv
// rtl/sap1_controller_sequencer.sv - SAP-1 ring-counter controller/sequencer
module sap1_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic [5:0] tstate,
  output logic       halted
);

  // One-hot ring positions; the encoding doubles as the tstate output.
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_t;

  state_t state, state_next;
  logic   halted_next;

  // State register: reset returns to T1 and clears the halt latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= T1;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= halted_next;
    end
  end

  // Next-state: advance the ring unless halted; HLT freezes the ring at T4.
  always_comb begin
    state_next  = state;
    halted_next = halted;
    if (!halted) begin
      case (state)
        T1: state_next = T2;
        T2: state_next = T3;
        T3: state_next = T4;
        T4: begin
          if (opcode == OP_HLT) begin
            halted_next = 1'b1;
          end else begin
            state_next = T5;
          end
        end
        T5: state_next = T6;
        T6: state_next = T1;
        default: state_next = T1;
      endcase
    end
  end

  // Strobe decode from ring position and opcode; everything is quiet once halted.
  always_comb begin
    cp = 1'b0;
    ep = 1'b0;
    lm = 1'b0;
    ce = 1'b0;
    li = 1'b0;
    ei = 1'b0;
    la = 1'b0;
    ea = 1'b0;
    su = 1'b0;
    eu = 1'b0;
    lb = 1'b0;
    lo = 1'b0;
    if (!halted) begin
      case (state)
        T1: begin
          ep = 1'b1;
          lm = 1'b1;
        end
        T2: cp = 1'b1;
        T3: begin
          ce = 1'b1;
          li = 1'b1;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ei = 1'b1;
            lm = 1'b1;
          end else if (opcode == OP_OUT) begin
            ea = 1'b1;
            lo = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ce = 1'b1;
            la = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ce = 1'b1;
            lb = 1'b1;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eu = 1'b1;
            la = 1'b1;
            su = (opcode == OP_SUB);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign tstate = state;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// tb/tb_sap1_controller_sequencer.sv - self-checking bench for sap1_controller_sequencer
module tb_sap1_controller_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  logic [5:0] tstate;
  logic       halted;

  int checks   = 0;
  int failures = 0;

  localparam logic [11:0] C_CP = 12'h800, C_EP = 12'h400, C_LM = 12'h200, C_CE = 12'h100;
  localparam logic [11:0] C_LI = 12'h080, C_EI = 12'h040, C_LA = 12'h020, C_EA = 12'h010;
  localparam logic [11:0] C_SU = 12'h008, C_EU = 12'h004, C_LB = 12'h002, C_LO = 12'h001;

  sap1_controller_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la), .ea(ea),
    .su(su), .eu(eu), .lb(lb), .lo(lo), .tstate(tstate), .halted(halted)
  );

  wire [11:0] ctrl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
  wire [4:0]  drivers = {ep, ce, ei, ea, eu};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: instruction step number 1..6 plus halt flag.
  int m_t     = 1;
  bit m_h     = 1'b0;
  bit m_valid = 1'b0;

  function automatic logic [11:0] exp_ctrl(int t, logic [3:0] op, bit h);
    logic [11:0] r;
    r = 12'h000;
    if (!h) begin
      if (t == 1) r = C_EP | C_LM;
      else if (t == 2) r = C_CP;
      else if (t == 3) r = C_CE | C_LI;
      else if (op == 4'h0) r = (t == 4) ? (C_EI | C_LM) : (t == 5) ? (C_CE | C_LA) : 12'h000;
      else if (op == 4'h1) r = (t == 4) ? (C_EI | C_LM) : (t == 5) ? (C_CE | C_LB) : (C_EU | C_LA);
      else if (op == 4'h2) r = (t == 4) ? (C_EI | C_LM) : (t == 5) ? (C_CE | C_LB) : (C_EU | C_LA | C_SU);
      else if (op == 4'hE) r = (t == 4) ? (C_EA | C_LO) : 12'h000;
    end
    return r;
  endfunction

  // Model advance on each rising edge, from the inputs as they stood before it.
  always @(posedge clk) begin
    if (rst) begin
      m_t = 1;
      m_h = 1'b0;
      m_valid = 1'b1;
    end else if (!m_h) begin
      if (m_t == 4 && opcode == 4'hF) m_h = 1'b1;
      else m_t = (m_t % 6) + 1;
    end
  end

  task automatic chk(string name, logic [11:0] got, logic [11:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("tstate", {6'b0, tstate}, {6'b0, 6'b1 << (m_t - 1)});
      chk("halted", {11'b0, halted}, {11'b0, m_h});
      chk("ctrl", ctrl, exp_ctrl(m_t, opcode, m_h));
      chk("bus_excl", {11'b0, ($countones(drivers) > 1)}, 12'h000);
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode = 4'h0;
    step(2);
    rst = 1'b0;
    // Reset and fetch
    chk("rst_tstate", {6'b0, tstate}, 12'h001);
    chk("rst_halted", {11'b0, halted}, 12'h000);
    chk("rst_t1", ctrl, C_EP | C_LM);
    step(1); chk("fetch_t2", ctrl, C_CP);
    step(1); chk("fetch_t3", ctrl, C_CE | C_LI);
    // LDA
    step(1); chk("lda_t4", ctrl, C_EI | C_LM);
    step(1); chk("lda_t5", ctrl, C_CE | C_LA);
    step(1); chk("lda_t6", ctrl, 12'h000);
    step(1); chk("lda_wrap", {6'b0, tstate}, 12'h001);
    // ADD then SUB
    opcode = 4'h1;
    step(5); chk("add_t6", ctrl, C_EU | C_LA);
    step(1); opcode = 4'h2;
    step(4); chk("sub_t5", ctrl, C_CE | C_LB);
    step(1); chk("sub_t6", ctrl, C_EU | C_LA | C_SU);
    step(1);
    // OUT
    opcode = 4'hE;
    step(3); chk("out_t4", ctrl, C_EA | C_LO);
    step(3);
    // HLT
    opcode = 4'hF;
    step(3); chk("hlt_t4", ctrl, 12'h000);
    chk("hlt_t4_nothalt", {11'b0, halted}, 12'h000);
    step(1); chk("hlt_halted", {11'b0, halted}, 12'h001);
    chk("hlt_tstate", {6'b0, tstate}, 12'h008);
    step(8); chk("hlt_frozen", {6'b0, tstate}, 12'h008);
    chk("hlt_quiet", ctrl, 12'h000);
    // Reset while halted
    rst = 1'b1;
    step(1); rst = 1'b0;
    chk("rst_halt_clr", {11'b0, halted}, 12'h000);
    chk("rst_halt_t1", {6'b0, tstate}, 12'h001);
    // Reset mid-SUB during T5
    opcode = 4'h2;
    step(4); chk("mid_t5_lb", ctrl, C_CE | C_LB);
    rst = 1'b1;
    step(1); rst = 1'b0;
    chk("mid_rst_t1", {6'b0, tstate}, 12'h001);
    chk("mid_rst_ctrl", ctrl, C_EP | C_LM);
    // Held reset stays at T1
    rst = 1'b1;
    step(3);
    chk("held_rst_ctrl", ctrl, C_EP | C_LM);
    rst = 1'b0;
    // Undefined opcode
    opcode = 4'h7;
    step(3); chk("nop_t4", ctrl, 12'h000);
    step(9); chk("nop_wrap", {6'b0, tstate}, 12'h001);
    // Randomized run checked by the per-cycle model compare
    for (int i = 0; i < 600; i++) begin
      if (m_t == 1 && !m_h) begin
        case ($urandom_range(0, 9))
          0, 1: opcode = 4'h0;
          2, 3: opcode = 4'h1;
          4, 5: opcode = 4'h2;
          6:    opcode = 4'hE;
          7:    opcode = 4'hF;
          default: opcode = 4'($urandom_range(3, 13));
        endcase
      end
      rst = (m_h && $urandom_range(0, 3) == 0) || ($urandom_range(0, 39) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
